alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the 16-bit Hack-style combinational ALU.
- Registers the six-bit zx/nx/zy/ny/f/no function and adds two serial modes: logical shift left and logical shift right.
- Adds valid/ready handshakes on both sides, a carry flag, and an optional shift-add multiplier.
- Sits between the register-file read stage and writeback in the next CPU revision.

Parameters:
- WIDTH, 16, datapath width in bits (>= 4).
- SHW, $clog2(WIDTH), width of the shift-amount field taken from y.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operand/command valid
- in_ready  output  1  block can accept a command this cycle
- x  input  WIDTH  operand X
- y  input  WIDTH  operand Y (in shift modes only y[SHW-1:0] is used, as the shift amount)
- c  input  6  function bits: c[0]=zx, c[1]=nx, c[2]=zy, c[3]=ny, c[4]=f, c[5]=no
- mode  input  2  00 function, 01 shift left, 10 shift right, 11 multiply
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out  output  WIDTH  registered result
- zr  output  1  out == 0
- ng  output  1  out[WIDTH-1]
- cy  output  1  carry / shifted-out bit / multiply overflow

Behaviour:
- Single clock domain; reset is synchronous and active-high (sampled on rising clk).
- FSM states: IDLE, EXEC, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready); forced 0 while reset is high.
- Accept occurs when in_valid & in_ready at edge N. x, y, c and mode are captured at N; later input changes are ignored.

Mode 00, function:
- zx: zero x; then nx: invert. zy: zero y; then ny: invert.
- f=1: WIDTH-bit add, carry out goes to cy. f=0: bitwise AND, cy=0.
- no: invert the result.
- FSM goes straight to DONE; out_valid is high after edge N (latency 1).

Mode 01/10, shift:
- Amount k = y[SHW-1:0].
- k=0: go directly to DONE with out=x, cy=0.
- k>0: go to EXEC and shift one bit per cycle, zero-filled, for k cycles. out_valid is high after edge N+k.
- cy = last bit shifted out.
- c is ignored in shift modes.

Mode 11:
- See Optional Feature.

DONE state:
- out, zr, ng, cy and out_valid are held stable until out_valid & out_ready.
- On handshake with a simultaneous new accept: load the new command; out_valid drops, or stays high if the new command is mode 00.
- On handshake with no new accept: return to IDLE and clear out_valid.

Flags:
- zr and ng are derived from the registered out and always match it.

Reset (any state, including mid-EXEC):
- Next edge enters IDLE.
- out=0, cy=0, out_valid=0, ng=0, zr=0 (flags forced to 0 during reset).
- Any in-flight operation is discarded.

Consumer-side rules:
- out_ready is ignored when out_valid=0.
- No combinational path from in_valid to out_valid.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined:
  - mode 11 is unsigned shift-add multiply of x by y with a 2*WIDTH accumulator, one partial product per EXEC cycle.
  - out_valid is high after edge N+WIDTH.
  - out = low WIDTH bits; cy = OR of the high WIDTH bits (overflow).
  - c is ignored.
- Undefined:
  - mode 11 decodes exactly as mode 00.
  - No multiplier hardware is synthesised.

Test Plan (WIDTH=16):
- Function, mode=00, c=6'b010000, x=5, y=7 -> out=12 one cycle after accept; zr=0, ng=0, cy=0. Repeat with x=16'hFFFF, y=1 -> out=0, zr=1, cy=1.
- Negate, mode=00, c=6'b111100, x=3 -> out=16'hFFFD, ng=1, zr=0.
- Shifts: mode=01, x=16'h0001, y=4 -> out=16'h0010 exactly 4 cycles after accept, in_ready=0 meanwhile. mode=10, x=16'h8001, y=1 -> out=16'h4000, cy=1. mode=01, y=0 -> out=x after 1 cycle.
- Backpressure: complete a mode-00 op, hold out_ready=0 for 3 cycles -> out and flags stable, out_valid=1, in_ready=0. Then raise out_ready with in_valid=1 (a new op) -> back-to-back accept, no bubble.
- Reset mid-shift: mode=01, y=10, assert reset at EXEC cycle 3 -> next edge out=0, out_valid=0, cy=0. One cycle after reset release in_ready=1.
- ALU_SEQ_MUL_EN defined, mode=11, x=300, y=300 -> out=16'h5F90, cy=1, out_valid 16 cycles after accept. With the macro undefined, the same stimulus with c=6'b010000 -> out=600 after 1 cycle.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle Hack-style ALU with valid/ready handshakes.
//   Mode 00 runs the registered zx/nx/zy/ny/f/no function (latency 1).
//   Modes 01/10 shift x left/right by y[SHW-1:0], one bit per cycle.
//   Mode 11 is a shift-add multiplier when ALU_SEQ_MUL_EN is defined.
//   Without ALU_SEQ_MUL_EN, mode 11 behaves exactly like mode 00.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   command handshake (x, y, c, mode)
//   out_valid/out_ready result handshake (out, zr, ng, cy)
//   zr/ng               zero/negative flags of the registered out
//   cy                  add carry, last shifted-out bit, or multiply overflow
module alu_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [5:0]       c,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             cy
);

    // Counter must hold WIDTH for the multiplier, so one bit wider than SHW.
    localparam int unsigned CNTW = SHW + 1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] work, work_n;
    logic [CNTW-1:0]  cnt, cnt_n;
    logic             shr, shr_n;
    logic [WIDTH-1:0] out_n;
    logic             cy_n, zr_n, ng_n, out_valid_n;

`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0] hi, hi_n;
    logic [WIDTH-1:0] xop, xop_n;
    logic             mulop, mulop_n;
    logic [WIDTH:0]   msum;
`endif

    logic             accept;
    logic             cmd_mul;
    logic             cmd_shift;
    logic [SHW-1:0]   k_in;
    logic             go_exec;

    // Function datapath
    logic [WIDTH-1:0] fx, fy, fres;
    logic [WIDTH:0]   fsum;
    logic             fcy;
    logic             sh_bit;

    assign accept    = in_valid & in_ready;
    assign cmd_shift = (mode == 2'b01) | (mode == 2'b10);
    assign k_in      = y[SHW-1:0];
`ifdef ALU_SEQ_MUL_EN
    assign cmd_mul   = (mode == 2'b11);
`else
    assign cmd_mul   = 1'b0;
`endif
    assign go_exec   = cmd_mul | (cmd_shift & (k_in != '0));

    // Hack function on the incoming operands, registered at accept
    always_comb begin
        fx   = c[0] ? '0 : x;
        fx   = c[1] ? ~fx : fx;
        fy   = c[2] ? '0 : y;
        fy   = c[3] ? ~fy : fy;
        fsum = {1'b0, fx} + {1'b0, fy};
        fres = c[4] ? fsum[WIDTH-1:0] : (fx & fy);
        fcy  = c[4] ? fsum[WIDTH] : 1'b0;
        fres = c[5] ? ~fres : fres;
    end

    // Bit that leaves the work register on this shift step
    assign sh_bit = shr ? work[0] : work[WIDTH-1];

`ifdef ALU_SEQ_MUL_EN
    // One partial product: add x into the high half when the low LSB is set
    assign msum = {1'b0, hi} + (work[0] ? {1'b0, xop} : '0);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, DONE: begin
                if (accept)
                    state_next = go_exec ? EXEC : DONE;
                else if ((state == DONE) && out_ready)
                    state_next = IDLE;
            end
            EXEC: begin
                if (cnt == CNTW'(1)) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output and datapath next-value logic
    always_comb begin
        logic load;
        logic fin_cy;
        in_ready    = ~reset & ((state == IDLE) | ((state == DONE) & out_ready));
        out_n       = out;
        cy_n        = cy;
        zr_n        = zr;
        ng_n        = ng;
        out_valid_n = out_valid;
        work_n      = work;
        cnt_n       = cnt;
        shr_n       = shr;
        load        = 1'b0;
        fin_cy      = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        hi_n        = hi;
        xop_n       = xop;
        mulop_n     = mulop;
`endif
        if ((state == DONE) && out_ready) out_valid_n = 1'b0;

        if (accept) begin
            if (go_exec) begin
                out_valid_n = 1'b0;
`ifdef ALU_SEQ_MUL_EN
                mulop_n = cmd_mul;
                hi_n    = '0;
                xop_n   = x;
                if (cmd_mul) begin
                    work_n = y;
                    cnt_n  = CNTW'(WIDTH);
                end else
`endif
                begin
                    work_n = x;
                    cnt_n  = CNTW'(k_in);
                    shr_n  = mode[1];
                end
            end else if (cmd_shift) begin
                out_n       = x;
                cy_n        = 1'b0;
                out_valid_n = 1'b1;
                load        = 1'b1;
            end else begin
                out_n       = fres;
                cy_n        = fcy;
                out_valid_n = 1'b1;
                load        = 1'b1;
            end
        end else if (state == EXEC) begin
            cnt_n = cnt - CNTW'(1);
`ifdef ALU_SEQ_MUL_EN
            if (mulop) begin
                work_n = {msum[0], work[WIDTH-1:1]};
                hi_n   = msum[WIDTH:1];
                fin_cy = |msum[WIDTH:1];
            end else
`endif
            begin
                work_n = shr ? (work >> 1) : (work << 1);
                fin_cy = sh_bit;
            end
            if (cnt == CNTW'(1)) begin
                out_n       = work_n;
                cy_n        = fin_cy;
                out_valid_n = 1'b1;
                load        = 1'b1;
            end
        end

        // Flags track out whenever it is written; reset leaves them at 0
        if (load) begin
            zr_n = (out_n == '0);
            ng_n = out_n[WIDTH-1];
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            out       <= '0;
            cy        <= 1'b0;
            zr        <= 1'b0;
            ng        <= 1'b0;
            out_valid <= 1'b0;
            work      <= '0;
            cnt       <= '0;
            shr       <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            hi        <= '0;
            xop       <= '0;
            mulop     <= 1'b0;
`endif
        end else begin
            out       <= out_n;
            cy        <= cy_n;
            zr        <= zr_n;
            ng        <= ng_n;
            out_valid <= out_valid_n;
            work      <= work_n;
            cnt       <= cnt_n;
            shr       <= shr_n;
`ifdef ALU_SEQ_MUL_EN
            hi        <= hi_n;
            xop       <= xop_n;
            mulop     <= mulop_n;
`endif
        end
    end

endmodule
